// File: rtl/seg7_pkg.sv
// Segment bit positions and the hex glyph table shared by the seven-segment
// scan driver and its decoder.
package seg7_pkg;

  localparam int SEG_WIDTH = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_WIDTH-1:0] SA = SEG_WIDTH'(1 << SEG_A);
  localparam logic [SEG_WIDTH-1:0] SB = SEG_WIDTH'(1 << SEG_B);
  localparam logic [SEG_WIDTH-1:0] SC = SEG_WIDTH'(1 << SEG_C);
  localparam logic [SEG_WIDTH-1:0] SD = SEG_WIDTH'(1 << SEG_D);
  localparam logic [SEG_WIDTH-1:0] SE = SEG_WIDTH'(1 << SEG_E);
  localparam logic [SEG_WIDTH-1:0] SF = SEG_WIDTH'(1 << SEG_F);
  localparam logic [SEG_WIDTH-1:0] SG = SEG_WIDTH'(1 << SEG_G);

  // Entry 15 (F) is listed first so that HEX_FONT[d] yields the glyph for d.
  localparam logic [15:0][SEG_WIDTH-1:0] HEX_FONT = {
    SA | SE | SF | SG,                  // F
    SA | SD | SE | SF | SG,             // E
    SB | SC | SD | SE | SG,             // d
    SA | SD | SE | SF,                  // C
    SC | SD | SE | SF | SG,             // b
    SA | SB | SC | SE | SF | SG,        // A
    SA | SB | SC | SD | SF | SG,        // 9
    SA | SB | SC | SD | SE | SF | SG,   // 8
    SA | SB | SC,                       // 7
    SA | SC | SD | SE | SF | SG,        // 6
    SA | SC | SD | SF | SG,             // 5
    SB | SC | SF | SG,                  // 4
    SA | SB | SC | SD | SG,             // 3
    SA | SB | SD | SE | SG,             // 2
    SB | SC,                            // 1
    SA | SB | SC | SD | SE | SF         // 0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-digit to seven-segment decoder, active-high segments.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]           digit,
  output logic [SEG_WIDTH-1:0] segments
);

  assign segments = HEX_FONT[digit];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scanner with frame-synchronous double-buffered
// display data and optional leading-zero blanking.
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [SEG_WIDTH-1:0]    seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    wrap;
  logic                    apply_now;

  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    disp_blank;
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_blank;
  logic                    pend_valid;

  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [IW-1:0]           msd_idx;
  logic [NUM_DIGITS-1:0]   sel_next;
  logic [SEG_WIDTH-1:0]    glyph;

  logic [SEG_WIDTH-1:0]    seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   sel_q;

  assign tick       = enable && (presc == PRESC_MAX);
  assign wrap       = tick && (idx == IDX_MAX);
  assign frame_done = wrap;
  // New data may reach the display only between frames or while not scanning.
  assign apply_now  = !enable || wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (!enable) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= wrap ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= 1'b0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= 1'b0;
      pend_valid <= 1'b0;
    end else if (load && apply_now) begin
      disp_value <= value;
      disp_dp    <= dp_in;
      disp_blank <= blank_lz;
      pend_valid <= 1'b0;
    end else if (pend_valid && apply_now) begin
      disp_value <= pend_value;
      disp_dp    <= pend_dp;
      disp_blank <= pend_blank;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_value <= value;
      pend_dp    <= dp_in;
      pend_blank <= blank_lz;
      pend_valid <= 1'b1;
    end
  end

  // msd_idx ends up at the highest nonzero digit, or 0 when all are zero.
  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    msd_idx   = '0;
    sel_next  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_digit   = disp_value[4*k +: 4];
        cur_dp      = disp_dp[k];
        sel_next[k] = 1'b1;
      end
      if (disp_value[4*k +: 4] != 4'd0) begin
        msd_idx = IW'(k);
      end
    end
    cur_blank = disp_blank && (idx > msd_idx);
  end

  seg7_hex_decode u_decode (
    .digit    (cur_digit),
    .segments (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      sel_q <= '0;
    end else if (!enable) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      sel_q <= '0;
    end else begin
      seg_q <= cur_blank ? '0 : glyph;
      dp_q  <= cur_dp;
      sel_q <= sel_next;
    end
  end

  assign seg       = seg_q ^ {SEG_WIDTH{ACTIVE_LOW}};
  assign dp        = dp_q ^ ACTIVE_LOW;
  assign digit_sel = sel_q ^ {NUM_DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: directed scenarios followed by
// randomized traffic, all compared against a cycle-count based reference model.
module tb_seven_seg_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam bit AL    = 1'b1;
  localparam int FRAME = ND * RD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            load = 1'b0;
  logic [4*ND-1:0] value = '0;
  logic [ND-1:0]   dp_in = '0;
  logic            blank_lz = 1'b0;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   digit_sel;
  logic            frame_done;

  seven_seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .ACTIVE_LOW  (AL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: scan position is just a count of enabled cycles.
  logic [6:0]      font [16];
  int              run_cnt;
  logic [4*ND-1:0] shown_val, pend_val;
  logic [ND-1:0]   shown_dp, pend_dp;
  logic            shown_blank, pend_blank, pend_valid;
  logic [6:0]      exp_seg;
  logic            exp_dp;
  logic [ND-1:0]   exp_sel;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic build_font();
    string names [16];
    names = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    for (int i = 0; i < 16; i++) begin
      font[i] = '0;
      for (int j = 0; j < names[i].len(); j++) begin
        font[i][int'(names[i][j]) - 97] = 1'b1;
      end
    end
  endtask

  function automatic logic model_fd();
    return enable && ((run_cnt % FRAME) == FRAME - 1);
  endfunction

  task automatic model_reset();
    run_cnt     = 0;
    shown_val   = '0;
    shown_dp    = '0;
    shown_blank = 1'b0;
    pend_val    = '0;
    pend_dp     = '0;
    pend_blank  = 1'b0;
    pend_valid  = 1'b0;
    exp_seg     = '0;
    exp_dp      = 1'b0;
    exp_sel     = '0;
  endtask

  task automatic model_edge();
    int   d;
    logic fd;
    logic now;
    d   = (run_cnt / RD) % ND;
    fd  = model_fd();
    now = !enable || fd;
    if (enable) begin
      exp_sel = ND'(1 << d);
      exp_dp  = shown_dp[d];
      if (shown_blank && d != 0 && (shown_val >> (4*d)) == 0)
        exp_seg = '0;
      else
        exp_seg = font[shown_val[4*d +: 4]];
    end else begin
      exp_sel = '0;
      exp_dp  = 1'b0;
      exp_seg = '0;
    end
    if (load && now) begin
      shown_val = value; shown_dp = dp_in; shown_blank = blank_lz; pend_valid = 1'b0;
    end else if (pend_valid && now) begin
      shown_val = pend_val; shown_dp = pend_dp; shown_blank = pend_blank; pend_valid = 1'b0;
    end else if (load) begin
      pend_val = value; pend_dp = dp_in; pend_blank = blank_lz; pend_valid = 1'b1;
    end
    run_cnt = enable ? (run_cnt + 1) % FRAME : 0;
  endtask

  // Called at a falling edge: drive inputs for one cycle and check the result.
  task automatic applyStimulus(input logic en, input logic ld, input logic [4*ND-1:0] val,
                               input logic [ND-1:0] dpv, input logic bl);
    enable = en; load = ld; value = val; dp_in = dpv; blank_lz = bl;
    #1;
    checkOutput("frame_done", 32'(frame_done), 32'(model_fd()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checkOutput("seg", 32'(seg), 32'(exp_seg ^ {7{AL}}));
    checkOutput("dp", 32'(dp), 32'(exp_dp ^ AL));
    checkOutput("digit_sel", 32'(digit_sel), 32'(exp_sel ^ {ND{AL}}));
  endtask

  task automatic idle(input logic en, input int n);
    for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, value, dp_in, blank_lz);
  endtask

  task automatic doReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_seg", 32'(seg), 32'(7'h7F));
    checkOutput("rst_dp", 32'(dp), 32'(1'b1));
    checkOutput("rst_digit_sel", 32'(digit_sel), 32'(4'hF));
    checkOutput("rst_frame_done", 32'(frame_done), 32'(1'b0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4*ND-1:0] rv;
    build_font();
    model_reset();
    #3;
    checkOutput("rst_seg", 32'(seg), 32'(7'h7F));
    checkOutput("rst_dp", 32'(dp), 32'(1'b1));
    checkOutput("rst_digit_sel", 32'(digit_sel), 32'(4'hF));
    checkOutput("rst_frame_done", 32'(frame_done), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic scan of 1A3F with a decimal point on digit 1.
    applyStimulus(1'b0, 1'b1, 16'h1A3F, 4'b0010, 1'b0);
    idle(1'b1, 2*FRAME);

    // Leading-zero blanking, including the all-zero value.
    applyStimulus(1'b1, 1'b1, 16'h0042, 4'b1000, 1'b1);
    idle(1'b1, 2*FRAME);
    applyStimulus(1'b1, 1'b1, 16'h0000, 4'b0000, 1'b1);
    idle(1'b1, 2*FRAME);

    // Mid-frame loads wait for the frame boundary; the last one wins.
    idle(1'b1, 3);
    applyStimulus(1'b1, 1'b1, 16'h1111, 4'b0001, 1'b0);
    idle(1'b1, FRAME + 2);
    applyStimulus(1'b1, 1'b1, 16'h2222, 4'b0000, 1'b0);
    idle(1'b1, 2);
    applyStimulus(1'b1, 1'b1, 16'h3333, 4'b0100, 1'b0);
    idle(1'b1, 2*FRAME);

    // Load on the frame_done cycle itself.
    for (int i = 0; i < FRAME && (run_cnt % FRAME) != FRAME - 1; i++) idle(1'b1, 1);
    applyStimulus(1'b1, 1'b1, 16'h5678, 4'b1001, 1'b0);
    idle(1'b1, FRAME);

    // Enable dropped mid-frame for 10 cycles.
    idle(1'b1, 6);
    idle(1'b0, 10);
    idle(1'b1, FRAME);

    // Reset during digit 2 with data pending.
    applyStimulus(1'b1, 1'b1, 16'h9ABC, 4'b1111, 1'b0);
    for (int i = 0; i < FRAME && ((run_cnt / RD) % ND) != 2; i++) idle(1'b1, 1);
    idle(1'b1, 1);
    doReset();
    idle(1'b1, 2*FRAME);

    // Randomized traffic.
    for (int n = 0; n < 1200; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        doReset();
      end else begin
        rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
        applyStimulus(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 7) == 0), rv,
                      4'($urandom), 1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, legal range 1..8: number of multiplexed digits.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 1000, minimum 2: clock cycles each digit stays lit.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0: 1 inverts all seg, dp and digit_sel outputs.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk (in, 1, rising-edge clock) and rst_n (in, 1, async active-low reset).
REQ-005 The block SHALL have input enable (1): scanning on when high.
REQ-006 The block SHALL have input load (1): single-cycle capture strobe.
REQ-007 The block SHALL have input value (4*NUM_DIGITS): hex digits, with digit k at bits [4k+3:4k] and digit 0 as the least significant.
REQ-008 The block SHALL have input dp_in (NUM_DIGITS): decimal point per digit.
REQ-009 The block SHALL have input blank_lz (1): enables leading-zero blanking.
REQ-010 The block SHALL have output seg (7): segments, with bit0=a through bit6=g.
REQ-011 The block SHALL have output dp (1): decimal point of the lit digit.
REQ-012 The block SHALL have output digit_sel (NUM_DIGITS): one-hot digit enable.
REQ-013 The block SHALL have output frame_done (1): one-cycle pulse at each completed scan.

Function
REQ-014 A free-running prescaler SHALL count 0..REFRESH_DIV-1 while enable=1; tick = (prescaler==REFRESH_DIV-1).
REQ-015 On tick, scan index SHALL advance 0,1..NUM_DIGITS-1, then wrap to 0.
REQ-016 frame_done SHALL pulse for exactly one cycle on the tick where the index wraps from NUM_DIGITS-1 to 0.
REQ-017 The load strobe SHALL capture value, dp_in and blank_lz into a pending register and set the pending flag.
REQ-018 Pending contents SHALL transfer to the display register only on the frame_done cycle, so that no frame mixes old and new data.
REQ-019 A load while pending is set SHALL overwrite the pending contents; the last load wins.
REQ-020 A load coinciding with frame_done SHALL be written directly to the display register, leaving pending clear.
REQ-021 While enable=0, the prescaler and index SHALL be held at 0, digit_sel/seg/dp SHALL be inactive, and any load SHALL apply to the display register on the next cycle.
REQ-022 Decoding SHALL use the standard hex font: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-023 With blank_lz=1, every digit above the most significant nonzero digit SHALL show no segments; digit 0 SHALL never be blanked, and all-zero input displays "0".
REQ-024 dp SHALL follow dp_in of the lit digit, including for blanked digits.
REQ-025 seg, dp and digit_sel SHALL be registered, reflecting the index and display register with one cycle of latency.
REQ-026 ACTIVE_LOW SHALL invert only the final registered outputs; internal logic SHALL be active-high.

Reset
REQ-027 On rst_n low, the prescaler, index, display register, pending register and pending flag SHALL be cleared to 0 asynchronously.
REQ-028 During and immediately after reset, seg, dp and digit_sel SHALL be inactive (all 0, or all 1 if ACTIVE_LOW=1), and frame_done SHALL be 0.
REQ-029 A reset in mid-frame SHALL discard pending data, and scanning SHALL restart at digit 0 with a full REFRESH_DIV dwell.

Structure
REQ-030 Package seg7_pkg SHALL hold the segment bit-index constants and the 16-entry hex font constant table.
REQ-031 Combinational sub-module seg7_hex_decode (4-bit in, 7-bit active-high out) SHALL be instantiated once on the selected digit.
REQ-032 The prescaler width SHALL be derived as clog2(REFRESH_DIV), and the index width as max(1, clog2(NUM_DIGITS)).

Verification
REQ-033 Scenario: NUM_DIGITS=4, REFRESH_DIV=4, load value=16'h1A3F -> digits 0..3 show F, 3, A, 1; digit_sel goes 0001, 0010, 0100, 1000; each digit dwells 4 cycles.
REQ-034 Scenario: load 16'h0042, blank_lz=1 -> digits 3 and 2 show seg=0, while digits 1 and 0 show 4 and 2; load 16'h0000 -> only digit 0 shows "0".
REQ-035 Scenario: load 16'h1111 in mid-frame -> display stays old data until frame_done, then shows 1111; two loads 16'h2222 then 16'h3333 in the same frame -> 3333 is shown.
REQ-036 Scenario: load asserted on the frame_done cycle -> new value appears on digit 0 of the very next frame.
REQ-037 Scenario: enable low for 10 cycles in mid-frame -> all outputs inactive; after enable returns high, digit 0 is lit after a 1-cycle latency.
REQ-038 Scenario: rst_n pulsed low during digit 2 with ACTIVE_LOW=1 -> seg=7'h7F, digit_sel=4'hF and pending is discarded; the restart shows 0 on digit 0.
